ahb_arbiter_slave: RTL and testbench

- Per-slave-port arbiter in the AHB interconnect; sits directly upstream of the slave-side payload mux.
- Chooses which master channel owns the slave's address phase, using round-robin among requesters.
- Holds a grant for the length of a burst.
- Drives a one-hot address-phase select (master→slave payload mux) and a one-hot data-phase select (slave→master response mux), each one clock apart in AHB pipeline order.

---
 rtl/ahb_arbiter_slave_pkg.sv | 43 ++++
 rtl/ahb_rr_pick.sv | 45 ++++
 rtl/ahb_arbiter_slave.sv | 174 +++++++++++++++++
 tb/tb_ahb_arbiter_slave.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ahb_arbiter_slave_pkg.sv
// Shared definitions for the per-slave AHB arbiter: bus encodings, the
// arbiter state type and the burst-length decode.
package ahb_arbiter_slave_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } hburst_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_OWN   = 2'd1,
    ARB_BURST = 2'd2
  } arb_state_t;

  // Number of beats in a burst; 0 marks the undefined-length INCR burst.
  function automatic logic [4:0] burst_len(input hburst_t burst);
    logic [4:0] len;
    case (burst)
      HBURST_SINGLE:                len = 5'd1;
      HBURST_INCR:                  len = 5'd0;
      HBURST_WRAP4,  HBURST_INCR4:  len = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  len = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: len = 5'd16;
      default:                      len = 5'd1;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/ahb_rr_pick.sv
// Combinational round-robin search: first asserted request found by walking
// upward from the priority pointer, wrapping at N-1 back to 0.
module ahb_rr_pick #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_valid
);

  localparam int SW = PTR_W + 1;

  logic [SW-1:0]    w_ch;
  logic [N-1:0]     w_grant;
  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  // Cyclic priority search starting at the pointer.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no path can leave a latch behind.
    w_ch    = '0;
    w_grant = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_ch = {1'b0, i_ptr} + SW'(k);
      if (w_ch >= SW'(N)) begin
        w_ch = w_ch - SW'(N);
      end
      if (!w_found && i_req[w_ch[PTR_W-1:0]]) begin
        w_found                   = 1'b1;
        w_idx                     = w_ch[PTR_W-1:0];
        w_grant[w_ch[PTR_W-1:0]]  = 1'b1;
      end
    end
  end

  assign o_grant = w_grant;
  assign o_idx   = w_idx;
  assign o_valid = w_found;

endmodule

// File: rtl/ahb_arbiter_slave.sv
// Per-slave-port AHB arbiter. Picks the master owning the slave's address
// phase (round-robin), freezes the grant for the length of a burst, and
// produces one-hot address-phase and data-phase selects for the muxes.
// Optional master-lock support is enabled by defining AHB_ARB_LOCK_EN.
module ahb_arbiter_slave
  import ahb_arbiter_slave_pkg::*;
#(
  parameter int CHANNEL_NUM = 2,
  parameter int BEAT_W      = 4
) (
  input  logic                     hclk,
  input  logic                     hreset_n,
  input  logic [CHANNEL_NUM-1:0]   hreq,
  input  logic [2*CHANNEL_NUM-1:0] htrans_in,
  input  logic [3*CHANNEL_NUM-1:0] hburst_in,
`ifdef AHB_ARB_LOCK_EN
  input  logic [CHANNEL_NUM-1:0]   hmastlock_in,
`endif
  input  logic                     hready_in,
  output logic [CHANNEL_NUM-1:0]   hsel_addr,
  output logic [CHANNEL_NUM-1:0]   hsel_data
);

  localparam int PTR_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

  arb_state_t             r_state;
  arb_state_t             w_state_nxt;
  logic [BEAT_W-1:0]      r_cnt;
  logic [BEAT_W-1:0]      w_cnt_nxt;
  logic                   r_incr;
  logic                   w_incr_nxt;
  logic [PTR_W-1:0]       r_ptr;
  logic [PTR_W-1:0]       w_ptr_nxt;
  logic [PTR_W-1:0]       r_owner;
  logic [PTR_W-1:0]       w_owner_nxt;
  logic [CHANNEL_NUM-1:0] r_hsel_addr;
  logic [CHANNEL_NUM-1:0] w_addr_nxt;
  logic [CHANNEL_NUM-1:0] r_hsel_data;

  htrans_t                w_trans [CHANNEL_NUM];
  hburst_t                w_burst [CHANNEL_NUM];
  htrans_t                w_own_trans;
  logic [4:0]             w_own_len;
  logic                   w_own_req;
  logic                   w_keep_lock;
  logic                   w_rearb;

  logic [CHANNEL_NUM-1:0] w_pick_grant;
  logic [PTR_W-1:0]       w_pick_idx;
  logic                   w_pick_valid;

  // Unpack the flat per-master HTRANS/HBURST buses into typed arrays.
  always_comb begin
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      w_trans[c] = htrans_t'(htrans_in[2*c +: 2]);
      w_burst[c] = hburst_t'(hburst_in[3*c +: 3]);
    end
  end

  assign w_own_trans = w_trans[r_owner];
  assign w_own_len   = burst_len(w_burst[r_owner]);
  assign w_own_req   = hreq[r_owner];

`ifdef AHB_ARB_LOCK_EN
  // A locked owner survives every arbitration point until it drops the lock.
  assign w_keep_lock = (|r_hsel_addr) && hmastlock_in[r_owner];
`else
  assign w_keep_lock = 1'b0;
`endif

  ahb_rr_pick #(
    .N     (CHANNEL_NUM),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .i_req   (hreq),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  // State register: FSM state, beat counter and INCR-burst flag.
  always_ff @(posedge hclk) begin
    // NOTE: reset is sampled on the clock edge only, and all state uses non-blocking assignments so every register sees pre-edge values.
    if (!hreset_n) begin
      r_state <= ARB_IDLE;
      r_cnt   <= '0;
      r_incr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_incr  <= w_incr_nxt;
    end
  end

  // Next-state: decide whether this edge holds the grant or re-arbitrates.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_incr_nxt  = r_incr;
    w_rearb     = 1'b0;
    if (hready_in) begin
      unique case (r_state)
        ARB_IDLE: w_rearb = 1'b1;
        ARB_OWN: begin
          if (w_own_req && (w_own_trans == HTRANS_NONSEQ) && (w_own_len != 5'd1)) begin
            w_state_nxt = ARB_BURST;
            w_incr_nxt  = (w_own_len == 5'd0);
            w_cnt_nxt   = (w_own_len == 5'd0) ? '0 : BEAT_W'(w_own_len - 5'd1);
          end else begin
            w_rearb = 1'b1;
          end
        end
        ARB_BURST: begin
          if (!w_own_req) begin
            w_rearb = 1'b1;
          end else if (r_incr) begin
            // Undefined-length burst lives as long as SEQ/BUSY continue.
            if ((w_own_trans != HTRANS_SEQ) && (w_own_trans != HTRANS_BUSY)) begin
              w_rearb = 1'b1;
            end
          end else if (w_own_trans == HTRANS_SEQ) begin
            w_cnt_nxt = (r_cnt != '0) ? r_cnt - 1'b1 : '0;
            if (r_cnt <= BEAT_W'(1)) begin
              w_rearb = 1'b1;
            end
          end else if (w_own_trans != HTRANS_BUSY) begin
            // IDLE or NONSEQ inside a fixed burst is an early termination.
            w_rearb = 1'b1;
          end
        end
        default: w_rearb = 1'b1;
      endcase
      if (w_rearb) begin
        w_incr_nxt  = 1'b0;
        w_cnt_nxt   = '0;
        w_state_nxt = (w_keep_lock || w_pick_valid) ? ARB_OWN : ARB_IDLE;
      end
    end
  end

  // Output decode: next address-phase grant, owner index and RR pointer.
  always_comb begin
    w_addr_nxt  = r_hsel_addr;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    if (w_rearb && !w_keep_lock) begin
      w_addr_nxt = w_pick_grant;
      if (w_pick_valid) begin
        w_owner_nxt = w_pick_idx;
        w_ptr_nxt   = (w_pick_idx == PTR_W'(CHANNEL_NUM - 1)) ? '0 : w_pick_idx + 1'b1;
      end
    end
  end

  // Grant registers: data-phase select follows the address phase per accepted transfer.
  always_ff @(posedge hclk) begin
    if (!hreset_n) begin
      r_hsel_addr <= '0;
      r_hsel_data <= '0;
      r_owner     <= '0;
      r_ptr       <= '0;
    end else if (hready_in) begin
      r_hsel_addr <= w_addr_nxt;
      r_hsel_data <= r_hsel_addr;
      r_owner     <= w_owner_nxt;
      r_ptr       <= w_ptr_nxt;
    end
  end

  assign hsel_addr = r_hsel_addr;
  assign hsel_data = r_hsel_data;

endmodule

// File: tb/tb_ahb_arbiter_slave.sv
// Self-checking bench for ahb_arbiter_slave (CHANNEL_NUM=2). Vectors carry
// the expected hsel_addr/hsel_data after the edge that samples them; the
// expectation is queued when the vector is driven and compared after the edge.
module tb_ahb_arbiter_slave;

  localparam logic [1:0] T_IDL = 2'd0;
  localparam logic [1:0] T_BSY = 2'd1;
  localparam logic [1:0] T_NSQ = 2'd2;
  localparam logic [1:0] T_SEQ = 2'd3;
  localparam logic [2:0] B_SGL = 3'd0;
  localparam logic [2:0] B_INC = 3'd1;
  localparam logic [2:0] B_I4  = 3'd3;
  localparam logic [2:0] B_I8  = 3'd5;

  typedef struct {
    string      tag;
    logic       rst_n;
    logic       rdy;
    logic [1:0] req;
    logic [3:0] trans;
    logic [5:0] burst;
    logic [1:0] lock;
    logic [1:0] exp_addr;
    logic [1:0] exp_data;
  } vec_t;

  typedef struct {
    string      tag;
    logic [1:0] addr;
    logic [1:0] data;
  } exp_t;

  logic       hclk;
  logic       hreset_n;
  logic [1:0] hreq;
  logic [3:0] htrans_in;
  logic [5:0] hburst_in;
  logic       hready_in;
  logic [1:0] hsel_addr;
  logic [1:0] hsel_data;
`ifdef AHB_ARB_LOCK_EN
  logic [1:0] hmastlock_in;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  vec_t tbl[$];

  ahb_arbiter_slave #(
    .CHANNEL_NUM (2),
    .BEAT_W      (4)
  ) dut (
    .hclk      (hclk),
    .hreset_n  (hreset_n),
    .hreq      (hreq),
    .htrans_in (htrans_in),
    .hburst_in (hburst_in),
`ifdef AHB_ARB_LOCK_EN
    .hmastlock_in (hmastlock_in),
`endif
    .hready_in (hready_in),
    .hsel_addr (hsel_addr),
    .hsel_data (hsel_data)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input string tag, input logic rst_n, input logic rdy,
                              input logic [1:0] req, input logic [3:0] trans,
                              input logic [5:0] burst, input logic [1:0] ea,
                              input logic [1:0] ed);
    vec_t v;
    v.tag      = tag;
    v.rst_n    = rst_n;
    v.rdy      = rdy;
    v.req      = req;
    v.trans    = trans;
    v.burst    = burst;
    v.lock     = 2'b00;
    v.exp_addr = ea;
    v.exp_data = ed;
    return v;
  endfunction

  // Compare DUT outputs against the oldest queued expectation.
  task automatic score();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({e.tag, "_addr"}, 32'(hsel_addr), 32'(e.addr));
    check({e.tag, "_data"}, 32'(hsel_data), 32'(e.data));
    check({e.tag, "_onehot"}, 32'($onehot0(hsel_addr) && $onehot0(hsel_data)), 32'd1);
  endtask

  // Drive one vector, queue its expectation, let one edge pass, then score.
  task automatic apply(input vec_t v);
    exp_t e;
    hreset_n  = v.rst_n;
    hready_in = v.rdy;
    hreq      = v.req;
    htrans_in = v.trans;
    hburst_in = v.burst;
`ifdef AHB_ARB_LOCK_EN
    hmastlock_in = v.lock;
`endif
    e.tag  = v.tag;
    e.addr = v.exp_addr;
    e.data = v.exp_data;
    exp_q.push_back(e);
    @(posedge hclk);
    #1;
    score();
  endtask

  initial begin
    vec_t v;
    hreset_n  = 1'b0;
    hready_in = 1'b1;
    hreq      = 2'b00;
    htrans_in = '0;
    hburst_in = '0;
`ifdef AHB_ARB_LOCK_EN
    hmastlock_in = 2'b00;
`endif

    // Reset, alternating SINGLEs, fixed INCR4, and an INCR burst.
    tbl.push_back(mk("rst0", 0, 1, 2'b00, {T_IDL, T_IDL}, {B_SGL, B_SGL}, 2'b00, 2'b00));
    tbl.push_back(mk("rst1", 0, 1, 2'b11, {T_NSQ, T_NSQ}, {B_SGL, B_SGL}, 2'b00, 2'b00));
    tbl.push_back(mk("rr1",  1, 1, 2'b11, {T_NSQ, T_NSQ}, {B_SGL, B_SGL}, 2'b01, 2'b00));
    tbl.push_back(mk("rr2",  1, 1, 2'b11, {T_NSQ, T_NSQ}, {B_SGL, B_SGL}, 2'b10, 2'b01));
    tbl.push_back(mk("rr3",  1, 1, 2'b11, {T_NSQ, T_NSQ}, {B_SGL, B_SGL}, 2'b01, 2'b10));
    tbl.push_back(mk("rr4",  1, 1, 2'b11, {T_NSQ, T_NSQ}, {B_SGL, B_SGL}, 2'b10, 2'b01));
    tbl.push_back(mk("rr5",  1, 1, 2'b00, {T_IDL, T_IDL}, {B_SGL, B_SGL}, 2'b00, 2'b10));
    tbl.push_back(mk("rr6",  1, 1, 2'b00, {T_IDL, T_IDL}, {B_SGL, B_SGL}, 2'b00, 2'b00));
    tbl.push_back(mk("i4_1", 1, 1, 2'b11, {T_NSQ, T_NSQ}, {B_SGL, B_I4},  2'b01, 2'b00));
    tbl.push_back(mk("i4_2", 1, 1, 2'b11, {T_NSQ, T_NSQ}, {B_SGL, B_I4},  2'b01, 2'b01));
    tbl.push_back(mk("i4_3", 1, 1, 2'b11, {T_NSQ, T_SEQ}, {B_SGL, B_I4},  2'b01, 2'b01));
    tbl.push_back(mk("i4_4", 1, 1, 2'b11, {T_NSQ, T_SEQ}, {B_SGL, B_I4},  2'b01, 2'b01));
    tbl.push_back(mk("i4_5", 1, 1, 2'b11, {T_NSQ, T_SEQ}, {B_SGL, B_I4},  2'b10, 2'b01));
    tbl.push_back(mk("i4_6", 1, 1, 2'b10, {T_NSQ, T_IDL}, {B_SGL, B_SGL}, 2'b10, 2'b10));
    tbl.push_back(mk("i4_7", 1, 1, 2'b00, {T_IDL, T_IDL}, {B_SGL, B_SGL}, 2'b00, 2'b10));
    tbl.push_back(mk("i4_8", 1, 1, 2'b00, {T_IDL, T_IDL}, {B_SGL, B_SGL}, 2'b00, 2'b00));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
    end

    // INCR4 with a 3-cycle wait state at beat 2 and one BUSY before beat 3.
    apply(mk("st1",  1, 1, 2'b11, {T_NSQ, T_NSQ}, {B_SGL, B_I4},  2'b01, 2'b00));
    apply(mk("st2",  1, 1, 2'b11, {T_NSQ, T_NSQ}, {B_SGL, B_I4},  2'b01, 2'b01));
    for (int i = 0; i < 3; i++) begin
      apply(mk($sformatf("st_wait%0d", i), 1, 0, 2'b11, {T_NSQ, T_SEQ}, {B_SGL, B_I4}, 2'b01, 2'b01));
    end
    apply(mk("st_b2",   1, 1, 2'b11, {T_NSQ, T_SEQ}, {B_SGL, B_I4},  2'b01, 2'b01));
    apply(mk("st_busy", 1, 1, 2'b11, {T_NSQ, T_BSY}, {B_SGL, B_I4},  2'b01, 2'b01));
    apply(mk("st_b3",   1, 1, 2'b11, {T_NSQ, T_SEQ}, {B_SGL, B_I4},  2'b01, 2'b01));
    apply(mk("st_b4",   1, 1, 2'b11, {T_NSQ, T_SEQ}, {B_SGL, B_I4},  2'b10, 2'b01));
    apply(mk("st_hold", 1, 0, 2'b10, {T_NSQ, T_IDL}, {B_SGL, B_SGL}, 2'b10, 2'b01));
    apply(mk("st_go",   1, 1, 2'b10, {T_NSQ, T_IDL}, {B_SGL, B_SGL}, 2'b10, 2'b10));
    apply(mk("st_off1", 1, 1, 2'b00, {T_IDL, T_IDL}, {B_SGL, B_SGL}, 2'b00, 2'b10));
    apply(mk("st_off2", 1, 1, 2'b00, {T_IDL, T_IDL}, {B_SGL, B_SGL}, 2'b00, 2'b00));

    // Channel 1 INCR burst: NONSEQ + 6 SEQ held against a competing ch0, ends on IDLE.
    apply(mk("inc_1", 1, 1, 2'b10, {T_NSQ, T_IDL}, {B_INC, B_SGL}, 2'b10, 2'b00));
    apply(mk("inc_2", 1, 1, 2'b11, {T_NSQ, T_NSQ}, {B_INC, B_SGL}, 2'b10, 2'b10));
    for (int i = 0; i < 6; i++) begin
      apply(mk($sformatf("inc_seq%0d", i), 1, 1, 2'b11, {T_SEQ, T_NSQ}, {B_INC, B_SGL}, 2'b10, 2'b10));
    end
    apply(mk("inc_end", 1, 1, 2'b01, {T_IDL, T_NSQ}, {B_INC, B_SGL}, 2'b01, 2'b10));
    apply(mk("inc_z1",  1, 1, 2'b00, {T_IDL, T_IDL}, {B_SGL, B_SGL}, 2'b00, 2'b01));
    apply(mk("inc_z2",  1, 1, 2'b00, {T_IDL, T_IDL}, {B_SGL, B_SGL}, 2'b00, 2'b00));

    // Reset in the middle of an INCR8, then a lone ch1 request.
    apply(mk("r8_1",   1, 1, 2'b01, {T_IDL, T_NSQ}, {B_SGL, B_I8},  2'b01, 2'b00));
    apply(mk("r8_2",   1, 1, 2'b01, {T_IDL, T_NSQ}, {B_SGL, B_I8},  2'b01, 2'b01));
    apply(mk("r8_3",   1, 1, 2'b01, {T_IDL, T_SEQ}, {B_SGL, B_I8},  2'b01, 2'b01));
    apply(mk("r8_rst", 0, 1, 2'b01, {T_IDL, T_SEQ}, {B_SGL, B_I8},  2'b00, 2'b00));
    apply(mk("r8_rel", 1, 1, 2'b00, {T_IDL, T_IDL}, {B_SGL, B_SGL}, 2'b00, 2'b00));
    apply(mk("r8_ch1", 1, 1, 2'b10, {T_NSQ, T_IDL}, {B_SGL, B_SGL}, 2'b10, 2'b00));
    apply(mk("r8_z1",  1, 1, 2'b00, {T_IDL, T_IDL}, {B_SGL, B_SGL}, 2'b00, 2'b10));
    apply(mk("r8_z2",  1, 1, 2'b00, {T_IDL, T_IDL}, {B_SGL, B_SGL}, 2'b00, 2'b00));

`ifdef AHB_ARB_LOCK_EN
    // Locked ch0 keeps the slave across SINGLEs until it drops hmastlock.
    v = mk("lk1", 1, 1, 2'b11, {T_NSQ, T_NSQ}, {B_SGL, B_SGL}, 2'b01, 2'b00); v.lock = 2'b01; apply(v);
    v = mk("lk2", 1, 1, 2'b11, {T_NSQ, T_NSQ}, {B_SGL, B_SGL}, 2'b01, 2'b01); v.lock = 2'b01; apply(v);
    v = mk("lk3", 1, 1, 2'b11, {T_NSQ, T_NSQ}, {B_SGL, B_SGL}, 2'b01, 2'b01); v.lock = 2'b01; apply(v);
    v = mk("lk4", 1, 1, 2'b11, {T_NSQ, T_NSQ}, {B_SGL, B_SGL}, 2'b10, 2'b01); v.lock = 2'b00; apply(v);
    v = mk("lk5", 1, 1, 2'b00, {T_IDL, T_IDL}, {B_SGL, B_SGL}, 2'b00, 2'b10); apply(v);
`else
    v = mk("tail", 1, 1, 2'b00, {T_IDL, T_IDL}, {B_SGL, B_SGL}, 2'b00, 2'b00);
    apply(v);
`endif

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
